vc_output_arbiter_2vc: RTL



---
 rtl/vc_output_arbiter_2vc.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/vc_output_arbiter_2vc.sv
// vc_output_arbiter_2vc
//   Takes flits from two per-VC show-ahead FIFOs and sends at most one flit per
//   cycle onto a single output link. Packets are wormhole-locked: once a VC
//   starts a packet, it keeps the link until that packet's tail flit. Per-VC
//   credit counters track free space in the downstream buffer, so a flit is
//   only sent when the receiver can accept it.
//
// Ports
//   clk            rising-edge clock
//   sclr_n         synchronous reset, active-low
//   fifo_q[2]      head flit of each VC FIFO (show-ahead)
//   fifo_empty[1:0]  per-VC FIFO empty
//   fifo_rdreq[1:0]  per-VC pop, combinational, one-hot or zero
//   credit_return[1:0]  one-cycle pulse: downstream freed one slot of that VC
//   out_data       registered output flit
//   out_valid      out_data valid this cycle
//   out_vc         VC of out_data
//   out_last       tail flag of out_data
//
// Optional build macro: VC_ARB_STATS_EN
//   When defined, adds the per-VC 32-bit counters flit_count[2] (grants) and
//   stall_count[2] (cycles with a non-empty FIFO that was not granted).
module vc_output_arbiter_2vc #(
  parameter int WIDTH    = 512,
  parameter int TAIL_BIT = WIDTH - 1,
  parameter int CREDITS  = 4
) (
  input  logic             clk,
  input  logic             sclr_n,
  input  logic [WIDTH-1:0] fifo_q [2],
  input  logic [1:0]       fifo_empty,
  output logic [1:0]       fifo_rdreq,
  input  logic [1:0]       credit_return,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_vc,
  output logic             out_last
`ifdef VC_ARB_STATS_EN
  ,
  output logic [31:0]      flit_count [2],
  output logic [31:0]      stall_count [2]
`endif
);

  localparam int CW = $clog2(CREDITS + 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state_reg;
  logic             lock_vc_reg;
  logic             rr_ptr_reg;
  logic [1:0]       elig;
  logic             grant_any;
  logic             grant_vc;
  logic [WIDTH-1:0] grant_flit;
  logic             grant_tail;

  // Per-VC credit counters; a VC is eligible with a head flit and a free slot.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_credit
      logic [CW-1:0] credit_reg;

      assign elig[gi] = !fifo_empty[gi] && (credit_reg != '0);

      always_ff @(posedge clk) begin
        if (!sclr_n) begin
          credit_reg <= CW'(CREDITS);
        end else if (fifo_rdreq[gi] && !credit_return[gi]) begin
          credit_reg <= credit_reg - CW'(1);
        end else if (!fifo_rdreq[gi] && credit_return[gi]) begin
          // A return with no outstanding flit means the receiver lost count.
          if (credit_reg == CW'(CREDITS))
            $error("vc_output_arbiter_2vc: credit overflow on VC%0d", gi);
          else
            credit_reg <= credit_reg + CW'(1);
        end
      end
    end
  endgenerate

  always_comb begin
    grant_any = 1'b0;
    grant_vc  = 1'b0;
    if (state_reg == LOCKED) begin
      // Mid-packet: only the owning VC may send; otherwise a bubble.
      grant_vc  = lock_vc_reg;
      grant_any = elig[lock_vc_reg];
    end else if (elig[0] && elig[1]) begin
      grant_any = 1'b1;
      grant_vc  = rr_ptr_reg;
    end else if (elig[0]) begin
      grant_any = 1'b1;
      grant_vc  = 1'b0;
    end else if (elig[1]) begin
      grant_any = 1'b1;
      grant_vc  = 1'b1;
    end
    grant_flit = fifo_q[grant_vc];
    grant_tail = grant_flit[TAIL_BIT];
    fifo_rdreq = '0;
    if (grant_any && sclr_n)
      fifo_rdreq[grant_vc] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      state_reg   <= IDLE;
      lock_vc_reg <= 1'b0;
      rr_ptr_reg  <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_vc      <= 1'b0;
      out_last    <= 1'b0;
    end else begin
      out_valid <= grant_any;
      if (grant_any) begin
        out_data <= grant_flit;
        out_vc   <= grant_vc;
        out_last <= grant_tail;
      end
      case (state_reg)
        IDLE: begin
          if (grant_any && !grant_tail) begin
            state_reg   <= LOCKED;
            lock_vc_reg <= grant_vc;
          end
        end
        LOCKED: begin
          if (grant_any && grant_tail)
            state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
      // Fairness is decided per packet: the other VC goes first next time.
      if (grant_any && grant_tail)
        rr_ptr_reg <= ~grant_vc;
    end
  end

`ifdef VC_ARB_STATS_EN
  generate
    for (gi = 0; gi < 2; gi++) begin : g_stats
      always_ff @(posedge clk) begin
        if (!sclr_n) begin
          flit_count[gi]  <= '0;
          stall_count[gi] <= '0;
        end else begin
          if (fifo_rdreq[gi])
            flit_count[gi] <= flit_count[gi] + 32'd1;
          if (!fifo_empty[gi] && !fifo_rdreq[gi])
            stall_count[gi] <= stall_count[gi] + 32'd1;
        end
      end
    end
  endgenerate
`endif

endmodule
